seven_segment_scanner: RTL and testbench

- Consumer end of the stopwatch BCD digit bus: takes the packed NUMBER_OF_DIGITS x 4-bit BCD value from the counter chain and drives a common-anode multiplexed seven-segment display.
- Scans one digit at a time, with a blanking (ghost-suppression) gap before each digit.
- Latches a coherent snapshot of the number once per frame so a digit rollover mid-scan never tears the display.

---
 rtl/seven_segment_scanner.sv | 180 ++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Multiplexed driver for a common-anode seven-segment display. It scans one
//   digit per slot, and each slot opens with a blanking gap that stops the
//   previous digit ghosting onto the next one. A snapshot of the BCD number is
//   latched at the start of every frame, so a counter rollover mid-scan cannot
//   tear the display.
//
// Optional feature: define SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN to suppress
//   leading zero digits. Digit 0 is always shown.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   enable    in   1 = display lit, 0 = anodes off (scanning continues)
//   number    in   packed BCD, digit d = number[4d+3:4d], digit 0 = LSD
//   dp_mask   in   1 = light decimal point on digit d
//   segments  out  active-low {g,f,e,d,c,b,a}
//   dp        out  active-low decimal point
//   anodes    out  active-low digit select, at most one bit low
module seven_segment_scanner #(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned DIGIT_REFRESH_RATE_IN_HZ    = 1000,
  parameter int unsigned BLANK_CYCLES                = 1000
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 enable,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic [NUMBER_OF_DIGITS-1:0]                          dp_mask,
  output logic [6:0]                                           segments,
  output logic                                                 dp,
  output logic [NUMBER_OF_DIGITS-1:0]                          anodes
);

  localparam int unsigned DIGIT_PERIOD_CYCLES =
    BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_REFRESH_RATE_IN_HZ;
  localparam int unsigned BPD   = NUMBER_OF_BITS_PER_DIGIT;
  localparam int unsigned NUM_W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int unsigned CNT_W =
    (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam int unsigned IDX_W =
    (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUMBER_OF_DIGITS - 1);

  // Slot phase encoding
  localparam logic [0:0] PH_GHOST = 1'b0;
  localparam logic [0:0] PH_ON    = 1'b1;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Reject parameter sets that would leave no visible time in a slot
  generate
    if (DIGIT_PERIOD_CYCLES == 0) begin : g_bad_period
      $error("seven_segment_scanner: DIGIT_PERIOD_CYCLES must be non-zero");
    end
    if (BLANK_CYCLES >= DIGIT_PERIOD_CYCLES) begin : g_bad_blank
      $error("seven_segment_scanner: BLANK_CYCLES must be less than DIGIT_PERIOD_CYCLES");
    end
  endgenerate

  // Active-low segment pattern for one BCD digit; non-decimal codes show a dash
  function automatic logic [6:0] decode_bcd(input logic [BPD-1:0] value);
    logic [6:0] seg;
    seg = SEG_DASH;
    case (32'(value))
      0:       seg = 7'h40;
      1:       seg = 7'h79;
      2:       seg = 7'h24;
      3:       seg = 7'h30;
      4:       seg = 7'h19;
      5:       seg = 7'h12;
      6:       seg = 7'h02;
      7:       seg = 7'h78;
      8:       seg = 7'h00;
      9:       seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]            slot_cnt_q,  slot_cnt_d;
  logic [IDX_W-1:0]            digit_idx_q, digit_idx_d;
  logic [0:0]                  phase_q,     phase_d;
  logic [NUM_W-1:0]            snapshot_q,  snapshot_d;
  logic [NUMBER_OF_DIGITS-1:0] anodes_q,    anodes_d;
  logic [6:0]                  segments_q,  segments_d;
  logic                        dp_q,        dp_d;

  logic                        frame_start;
  logic [NUM_W-1:0]            snapshot_view;
  logic [BPD-1:0]              cur_digit;
  logic [NUMBER_OF_DIGITS-1:0] lz_suppress;
  logic                        digit_hidden;
  logic                        show_digit;

  // Slot counter, digit index, phase and frame snapshot
  always_comb begin
    slot_cnt_d  = slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end

    phase_d = (32'(slot_cnt_d) < BLANK_CYCLES) ? PH_GHOST : PH_ON;

    // The number being latched this cycle is also what the first slot shows,
    // so a zero-length blank still displays the new frame's value.
    frame_start   = (slot_cnt_q == '0) && (digit_idx_q == '0);
    snapshot_view = frame_start ? number : snapshot_q;
    snapshot_d    = snapshot_view;
  end

  assign cur_digit = snapshot_view[32'(digit_idx_q) * BPD +: BPD];

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A digit is hidden when it and all digits above it are zero
  always_comb begin
    lz_suppress = '0;
    zero_run    = 1'b1;
    for (int d = int'(NUMBER_OF_DIGITS) - 1; d > 0; d--) begin
      zero_run       = zero_run & (snapshot_view[32'(d) * BPD +: BPD] == '0);
      lz_suppress[d] = zero_run;
    end
  end
`else
  always_comb begin
    lz_suppress = '0;
  end
`endif

  assign digit_hidden = lz_suppress[digit_idx_q];

  // Registered display outputs for the digit selected by the current state
  always_comb begin
    anodes_d   = '1;
    segments_d = SEG_OFF;
    dp_d       = 1'b1;
    show_digit = (phase_q == PH_ON) && !digit_hidden;
    if (show_digit) begin
      segments_d = decode_bcd(cur_digit);
      dp_d       = ~dp_mask[digit_idx_q];
      if (enable) begin
        anodes_d[digit_idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      phase_q     <= PH_GHOST;
      snapshot_q  <= '0;
      anodes_q    <= '1;
      segments_q  <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      phase_q     <= phase_d;
      snapshot_q  <= snapshot_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segments_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Self-checking bench for seven_segment_scanner with an 8-cycle digit slot
//   (2 blank cycles) and a 32-cycle frame. Expected outputs come from constant
//   tables, hand sequences, and a cycle-indexed reference model.
module tb_seven_segment_scanner;

  localparam int ND    = 4;
  localparam int PER   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * PER;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] number;
  logic [3:0]  dp_mask;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS            (4),
    .NUMBER_OF_BITS_PER_DIGIT    (4),
    .BOARD_CLOCK_FREQUENCY_IN_HZ (16),
    .DIGIT_REFRESH_RATE_IN_HZ    (2),
    .BLANK_CYCLES                (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .number   (number),
    .dp_mask  (dp_mask),
    .segments (segments),
    .dp       (dp),
    .anodes   (anodes)
  );

  int n_pass  = 0;
  int n_total = 0;
  int t_next  = 0;   // cycles since reset release, as seen by the next edge
  int t_obs   = -1;  // cycle index the visible outputs belong to
  logic [15:0] msnap = '0;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dpm;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpx;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] lut [10];
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 9) return 7'h3F;
    return lut[v];
  endfunction

  // Expected outputs for cycle t of a frame, computed from slot arithmetic
  function automatic void model(input int t, input logic [15:0] snap, input logic en,
                                input logic [3:0] dpm, output logic [3:0] an,
                                output logic [6:0] seg, output logic dpx);
    int  s    = int'(snap);
    int  slot = t % PER;
    int  idx  = (t / PER) % ND;
    int  dig  = (s >> (4 * idx)) & 15;
    bit  lit  = (slot >= BLANK);
    bit  supp = 1'b0;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    supp = (idx > 0) && ((s >> (4 * idx)) == 0);
`endif
    an  = 4'hF;
    seg = 7'h7F;
    dpx = 1'b1;
    if (lit && !supp) begin
      seg = seg_of(dig);
      dpx = ~dpm[idx];
      if (en) an[idx] = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, t_obs);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    if (rst) begin
      msnap  = '0;
      e_an   = 4'hF;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      t_obs  = -1;
      t_next = 0;
    end else begin
      if (t_next % FRAME == 0) msnap = number;
      model(t_next, msnap, enable, dp_mask, e_an, e_seg, e_dp);
      t_obs  = t_next;
      t_next = t_next + 1;
    end
    #1;
    check("mdl_anodes", 32'(anodes), 32'(e_an));
    check("mdl_segments", 32'(segments), 32'(e_seg));
    check("mdl_dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (t_obs != target && guard < 200) begin
      step();
      guard++;
    end
    if (t_obs != target) check("run_until_timeout", 32'(t_obs), 32'(target));
  endtask

  task automatic check_off(input string name);
    check({name, "_anodes"}, 32'(anodes), 32'h0000_000F);
    check({name, "_segments"}, 32'(segments), 32'h0000_007F);
    check({name, "_dp"}, 32'(dp), 32'h0000_0001);
  endtask

  initial begin
    vecs[0] = '{16'h5942, 4'b0100, 0, 4'b1110, 7'h24, 1'b1};
    vecs[1] = '{16'h5942, 4'b0100, 1, 4'b1101, 7'h19, 1'b1};
    vecs[2] = '{16'h5942, 4'b0100, 2, 4'b1011, 7'h10, 1'b0};
    vecs[3] = '{16'h5942, 4'b0100, 3, 4'b0111, 7'h12, 1'b1};
    vecs[4] = '{16'h00A3, 4'b0000, 1, 4'b1101, 7'h3F, 1'b1};
    vecs[5] = '{16'h00A3, 4'b0000, 0, 4'b1110, 7'h30, 1'b1};

    rst     = 1'b1;
    enable  = 1'b1;
    number  = 16'h0000;
    dp_mask = 4'b0000;

    // Reset state
    do_reset();
    check_off("reset");

    // Table: each digit lit for 6 cycles after 2 blank cycles
    for (int v = 0; v < 6; v++) begin
      number  = vecs[v].num;
      dp_mask = vecs[v].dpm;
      enable  = 1'b1;
      do_reset();
      for (int k = 0; k < FRAME; k++) begin
        step();
        if ((t_obs / PER) % ND == vecs[v].digit) begin
          if (t_obs % PER >= BLANK) begin
            check("vec_anodes", 32'(anodes), 32'(vecs[v].an));
            check("vec_segments", 32'(segments), 32'(vecs[v].seg));
            check("vec_dp", 32'(dp), 32'(vecs[v].dpx));
          end else begin
            check_off("vec_blank");
          end
        end
      end
    end

    // Mid-frame number change stays invisible until the next frame
    number  = 16'h0009;
    dp_mask = 4'b0000;
    do_reset();
    run_until(9);
    number = 16'h0010;
    run_until(10);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    check("snap_cur_d1_anodes", 32'(anodes), 32'h0000_000F);
    check("snap_cur_d1_segments", 32'(segments), 32'h0000_007F);
`else
    check("snap_cur_d1_anodes", 32'(anodes), 32'h0000_000D);
    check("snap_cur_d1_segments", 32'(segments), 32'h0000_0040);
`endif
    run_until(FRAME + 2);
    check("snap_next_d0_anodes", 32'(anodes), 32'h0000_000E);
    check("snap_next_d0_segments", 32'(segments), 32'h0000_0040);
    run_until(FRAME + 10);
    check("snap_next_d1_anodes", 32'(anodes), 32'h0000_000D);
    check("snap_next_d1_segments", 32'(segments), 32'h0000_0079);

    // Enable dropped for 5 cycles during digit 2's lit phase
    number  = 16'h5942;
    dp_mask = 4'b0100;
    enable  = 1'b1;
    do_reset();
    run_until(18);
    check("en_before_anodes", 32'(anodes), 32'h0000_000B);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("en_off_anodes", 32'(anodes), 32'h0000_000F);
    end
    enable = 1'b1;
    run_until(25);
    check_off("en_d3_blank");
    run_until(26);
    check("en_d3_anodes", 32'(anodes), 32'h0000_0007);
    check("en_d3_segments", 32'(segments), 32'h0000_0012);

    // Reset during digit 3's lit phase
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_off("rst_mid");
    step();
    check_off("rst_blank1");
    step();
    check("rst_d0_anodes", 32'(anodes), 32'h0000_000E);
    check("rst_d0_segments", 32'(segments), 32'h0000_0024);

    // Leading zero digits
    number  = 16'h0007;
    dp_mask = 4'b0000;
    do_reset();
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (t_obs == 2) begin
        check("lz_d0_anodes", 32'(anodes), 32'h0000_000E);
        check("lz_d0_segments", 32'(segments), 32'h0000_0078);
      end
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
      if (t_obs >= PER) check("lz_hidden_anodes", 32'(anodes), 32'h0000_000F);
`else
      if (t_obs == PER + 2) check("lz_d1_anodes", 32'(anodes), 32'h0000_000D);
`endif
    end

    // Randomized run against the reference model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] r;
      if ($urandom_range(0, 15) == 0) begin
        r      = 16'($urandom);
        number = r >> (4 * $urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
